// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-side memory bridge and its watchdog.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_t;

    localparam logic [31:0] DMEM_ERR_WORD = 32'hDEADBEEF;
    localparam logic [3:0]  BE_FULL       = 4'b1111;

    // The bus only understands whole-word addresses; byte lanes go out on be_o.
    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter that flags a bus transaction which has waited TIMEOUT_CYC cycles.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);

    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 16'd0;
        end else if (clr) begin
            count_reg <= 16'd0;
        end else if (run) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    // Only meaningful while a transaction is outstanding; a stale count never aborts.
    assign expired = run && (count_reg == LIMIT);

endmodule

// File: rtl/dmem_bridge.sv
// Turns each M-stage load/store into one request/addr-ok/data-ok bus transaction,
// stalling the pipeline until it retires and returning read data for one cycle.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic [3:0]  mem_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        req_o,
    output logic        wr_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        addr_ok_i,
    input  logic        data_ok_i,
    input  logic [31:0] rdata_i
);

    dmem_state_t state_reg;
    dmem_state_t state_next;

    logic        launch;
    logic        accept;
    logic        capture;
    logic        abort;
    logic        wd_run;
    logic        wd_expired;

    logic        req_reg;
    logic        wr_reg;
    logic        err_reg;
    logic [3:0]  be_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;

    logic        is_write;
    logic [3:0]  be_next;

    assign is_write = |mem_wen_i;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_lane
            assign be_next[gi] = is_write ? mem_wen_i[gi] : BE_FULL[gi];
        end
    endgenerate

    bus_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (launch),
        .run     (wd_run),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The watchdog wins over a response arriving in the very cycle it expires.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_en_i) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wd_expired) begin
                    state_next = ST_DONE;
                end else if (addr_ok_i && data_ok_i) begin
                    state_next = ST_DONE;
                end else if (addr_ok_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wd_expired || data_ok_i) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        launch  = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        wd_run  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stall_o = mem_en_i;
                launch  = mem_en_i;
            end
            ST_REQ: begin
                stall_o = 1'b1;
                wd_run  = 1'b1;
                abort   = wd_expired;
                accept  = addr_ok_i && !wd_expired;
                capture = addr_ok_i && data_ok_i && !wd_expired;
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                wd_run  = 1'b1;
                abort   = wd_expired;
                capture = data_ok_i && !wd_expired;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
        if (rst) begin
            stall_o = 1'b0;
        end
    end

    // Bus fields stay latched after retirement; only a new launch changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg   <= 1'b0;
            wr_reg    <= 1'b0;
            err_reg   <= 1'b0;
            be_reg    <= 4'b0000;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            rdata_reg <= 32'h0;
        end else begin
            err_reg <= abort;
            if (launch) begin
                req_reg   <= 1'b1;
                wr_reg    <= is_write;
                be_reg    <= be_next;
                addr_reg  <= word_align(mem_addr_i);
                wdata_reg <= mem_wdata_i;
            end else if (accept || abort) begin
                req_reg <= 1'b0;
            end
            if (capture) begin
                rdata_reg <= wr_reg ? 32'h0 : rdata_i;
            end else if (abort) begin
                rdata_reg <= DMEM_ERR_WORD;
            end
        end
    end

    assign req_o       = req_reg;
    assign wr_o        = wr_reg;
    assign be_o        = be_reg;
    assign addr_o      = addr_reg;
    assign wdata_o     = wdata_reg;
    assign err_o       = err_reg;
    assign mem_rdata_o = rdata_reg;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a stimulus process queues expected retirements,
// a bus responder plays the SRAM side, and a monitor checks every retired transaction.
module tb_dmem_bridge;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          stall;
        int          req;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mem_en_s [2];
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] bus_rdata;

    logic [31:0] rdata_s [2];
    logic        stall_s [2];
    logic        err_s   [2];
    logic        req_s   [2];
    logic        wr_s    [2];
    logic [3:0]  be_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];

    dmem_bridge dut_a (
        .clk         (clk),
        .rst         (rst),
        .mem_en_i    (mem_en_s[0]),
        .mem_wen_i   (mem_wen),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (rdata_s[0]),
        .stall_o     (stall_s[0]),
        .err_o       (err_s[0]),
        .req_o       (req_s[0]),
        .wr_o        (wr_s[0]),
        .be_o        (be_s[0]),
        .addr_o      (addr_s[0]),
        .wdata_o     (wdata_s[0]),
        .addr_ok_i   (addr_ok),
        .data_ok_i   (data_ok),
        .rdata_i     (bus_rdata)
    );

    dmem_bridge #(
        .TIMEOUT_CYC (4)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .mem_en_i    (mem_en_s[1]),
        .mem_wen_i   (mem_wen),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (rdata_s[1]),
        .stall_o     (stall_s[1]),
        .err_o       (err_s[1]),
        .req_o       (req_s[1]),
        .wr_o        (wr_s[1]),
        .be_o        (be_s[1]),
        .addr_o      (addr_s[1]),
        .wdata_o     (wdata_s[1]),
        .addr_ok_i   (addr_ok),
        .data_ok_i   (data_ok),
        .rdata_i     (bus_rdata)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int          act_inst    = 0;
    int          aok_lat     = 1;
    int          dok_lat     = 0;
    logic        never_ok    = 1'b0;
    logic        stale_pulse = 1'b0;
    logic [31:0] bus_word    = 32'h0;
    int          probe       = 0;
    logic        end_probe   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus responder: addr_ok in the aok_lat-th REQ cycle, data_ok dok_lat cycles later.
    int req_seen  = 0;
    int wait_left = 0;
    initial begin
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            addr_ok   = 1'b0;
            data_ok   = 1'b0;
            bus_rdata = 32'h0;
            if (rst) begin
                req_seen  = 0;
                wait_left = 0;
            end else if (stale_pulse) begin
                data_ok   = 1'b1;
                bus_rdata = 32'hFFFF_FFFF;
            end else if (req_s[act_inst]) begin
                req_seen++;
                if (!never_ok && req_seen == aok_lat) begin
                    addr_ok = 1'b1;
                    if (dok_lat == 0) begin
                        data_ok   = 1'b1;
                        bus_rdata = bus_word;
                    end else begin
                        wait_left = dok_lat;
                    end
                end
            end else begin
                req_seen = 0;
                if (wait_left > 0) begin
                    wait_left--;
                    if (wait_left == 0) begin
                        data_ok   = 1'b1;
                        bus_rdata = bus_word;
                    end
                end
            end
        end
    end

    // Monitor: counts stall/REQ cycles per transaction and checks on each retirement.
    int          stall_cnt [2];
    int          req_cnt   [2];
    logic        prev_stall[2];
    logic        cap_wr    [2];
    logic [3:0]  cap_be    [2];
    logic [31:0] cap_addr  [2];
    logic [31:0] cap_wdata [2];
    logic        retire_v;
    logic        changed_v;
    exp_t        e_m;

    always @(negedge clk) begin
        if (probe == 1) begin
            chk("rst_stall", 32'(stall_s[0]), 32'h0);
            chk("rst_req",   32'(req_s[0]),   32'h0);
            chk("rst_wr",    32'(wr_s[0]),    32'h0);
            chk("rst_err",   32'(err_s[0]),   32'h0);
            chk("rst_be",    32'(be_s[0]),    32'h0);
            chk("rst_addr",  addr_s[0],       32'h0);
            chk("rst_wdata", wdata_s[0],      32'h0);
            chk("rst_rdata", rdata_s[0],      32'h0);
        end else if (probe == 2) begin
            chk("stall_forced_low_in_rst", 32'(stall_s[0]), 32'h0);
        end
        if (end_probe) begin
            chk("queue_empty", 32'(exp_q.size()), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            retire_v = 1'b0;
            if (rst) begin
                stall_cnt[i]  = 0;
                req_cnt[i]    = 0;
                prev_stall[i] = 1'b0;
            end else begin
                if (req_s[i]) begin
                    if (req_cnt[i] == 0) begin
                        cap_wr[i]    = wr_s[i];
                        cap_be[i]    = be_s[i];
                        cap_addr[i]  = addr_s[i];
                        cap_wdata[i] = wdata_s[i];
                    end else begin
                        changed_v = (cap_wr[i] !== wr_s[i]) || (cap_be[i] !== be_s[i]) ||
                                    (cap_addr[i] !== addr_s[i]) || (cap_wdata[i] !== wdata_s[i]);
                        chk("req_fields_stable", 32'(changed_v), 32'h0);
                    end
                    req_cnt[i]++;
                end
                if (stall_s[i]) begin
                    stall_cnt[i]++;
                    if (stall_cnt[i] == 300) begin
                        chk("stall_bound", 32'(stall_cnt[i]), 32'd0);
                    end
                end else if (prev_stall[i]) begin
                    retire_v = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e_m = exp_q.pop_front();
                        $display("txn inst=%0d wr=%0d be=%b addr=%h wdata=%h rdata=%h err=%0d stall=%0d req=%0d",
                                 i, cap_wr[i], cap_be[i], cap_addr[i], cap_wdata[i], rdata_s[i],
                                 err_s[i], stall_cnt[i], req_cnt[i]);
                        chk("txn_inst",   32'(i),            32'(e_m.inst));
                        chk("txn_rdata",  rdata_s[i],        e_m.rdata);
                        chk("txn_err",    32'(err_s[i]),     32'(e_m.err));
                        chk("txn_stall",  32'(stall_cnt[i]), 32'(e_m.stall));
                        chk("txn_req",    32'(req_cnt[i]),   32'(e_m.req));
                        chk("txn_wr",     32'(cap_wr[i]),    32'(e_m.wr));
                        chk("txn_be",     32'(cap_be[i]),    32'(e_m.be));
                        chk("txn_addr",   cap_addr[i],       e_m.addr);
                        chk("txn_wdata",  cap_wdata[i],      e_m.wdata);
                    end
                    stall_cnt[i] = 0;
                    req_cnt[i]   = 0;
                end
                if (err_s[i] && !retire_v) begin
                    chk("err_outside_done", 32'(err_s[i]), 32'h0);
                end
                prev_stall[i] = stall_s[i];
            end
        end
    end

    task automatic do_op(input int inst, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input int aok, input int dok, input logic never,
                         input logic [31:0] word, input logic [31:0] x_rdata, input logic x_err,
                         input int x_stall, input int x_req, input logic x_wr, input logic [3:0] x_be,
                         input logic [31:0] x_addr, input logic [31:0] x_wdata);
        exp_t e;
        int   n;
        @(posedge clk);
        #2;
        act_inst = inst;
        aok_lat  = aok;
        dok_lat  = dok;
        never_ok = never;
        bus_word = word;
        e.inst   = inst;
        e.rdata  = x_rdata;
        e.err    = x_err;
        e.stall  = x_stall;
        e.req    = x_req;
        e.wr     = x_wr;
        e.be     = x_be;
        e.addr   = x_addr;
        e.wdata  = x_wdata;
        exp_q.push_back(e);
        mem_en_s[inst] = 1'b1;
        mem_wen        = wen;
        mem_addr       = addr;
        mem_wdata      = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_s[inst] && n < 400);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #2;
        mem_en_s[0] = 1'b0;
        mem_en_s[1] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        mem_en_s[0] = 1'b0;
        mem_en_s[1] = 1'b0;
        mem_wen     = 4'b0000;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #2 probe = 1;
        @(posedge clk);
        #2 probe = 0;
        rst = 1'b0;

        // Zero-wait load
        do_op(0, 4'b0000, 32'h0000_1006, 32'h5555_AAAA, 1, 0, 1'b0, 32'h1234_5678,
              32'h1234_5678, 1'b0, 2, 1, 1'b0, 4'b1111, 32'h0000_1004, 32'h5555_AAAA);
        go_idle();

        // Reset while waiting for data, then a stale data_ok in IDLE
        @(posedge clk);
        #2;
        act_inst    = 0;
        aok_lat     = 1;
        dok_lat     = 50;
        never_ok    = 1'b0;
        bus_word    = 32'h7777_7777;
        mem_wen     = 4'b0000;
        mem_addr    = 32'h0000_5000;
        mem_wdata   = 32'h0;
        mem_en_s[0] = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst         = 1'b1;
        mem_en_s[0] = 1'b0;
        probe       = 2;
        @(posedge clk);
        #2;
        rst         = 1'b0;
        probe       = 0;
        stale_pulse = 1'b1;
        @(posedge clk);
        #2 stale_pulse = 1'b0;
        @(posedge clk);
        #2 probe = 1;
        @(posedge clk);
        #2 probe = 0;

        // Delayed store
        do_op(0, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 3, 2, 1'b0, 32'hFFFF_0000,
              32'h0000_0000, 1'b0, 6, 3, 1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000);
        go_idle();

        // Back-to-back load then store
        do_op(0, 4'b0000, 32'h0000_3008, 32'h0000_0000, 1, 1, 1'b0, 32'h0BAD_F00D,
              32'h0BAD_F00D, 1'b0, 3, 1, 1'b0, 4'b1111, 32'h0000_3008, 32'h0000_0000);
        do_op(0, 4'b0011, 32'h0000_300F, 32'h0000_5A5A, 2, 0, 1'b0, 32'h1111_1111,
              32'h0000_0000, 1'b0, 3, 2, 1'b1, 4'b0011, 32'h0000_300C, 32'h0000_5A5A);
        go_idle();

        // Timeout on the TIMEOUT_CYC = 4 instance
        do_op(1, 4'b0000, 32'h0000_4000, 32'h0000_0000, 1, 0, 1'b1, 32'h0,
              32'hDEAD_BEEF, 1'b1, 6, 5, 1'b0, 4'b1111, 32'h0000_4000, 32'h0000_0000);
        go_idle();

        repeat (5) @(posedge clk);
        #2 end_probe = 1'b1;
        @(posedge clk);
        #2 end_probe = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
